// File: rtl/fe_tx_framer.sv
// Transmit framer: sends LEN_H, LEN_L, CMD, LEN payload bytes from the FIFO and an
// optional XOR checksum, one byte per tx_en/tx_busy handshake with the UART.
module fe_tx_framer #(
  parameter int LEN_W  = 16,
  parameter bit CHK_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       cmd,
  input  logic [LEN_W-1:0] len,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_dout,
  output logic             fifo_rd,
  input  logic             tx_busy,
  output logic             tx_en,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             tx_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_H, S_LEN_L, S_CMD, S_WAIT, S_RD, S_RDW, S_LAT, S_CHK, S_FIN
  } state_t;

  state_t           state_reg;
  state_t           ret_reg;    // where WAIT goes once the byte is out; S_RD means "payload decision"
  logic             guard_reg;  // skips tx_busy in the cycle right after tx_en
  logic [7:0]       cmd_reg;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] cnt_reg;
  logic [7:0]       chk_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      ret_reg   <= S_IDLE;
      guard_reg <= 1'b0;
      cmd_reg   <= '0;
      len_reg   <= '0;
      cnt_reg   <= '0;
      chk_reg   <= '0;
      fifo_rd   <= 1'b0;
      tx_en     <= 1'b0;
      tx_data   <= '0;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_en   <= 1'b0;
      fifo_rd <= 1'b0;
      tx_done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          // the tx_done cycle is still part of the old frame
          if (start && !tx_done) begin
            cmd_reg   <= cmd;
            len_reg   <= len;
            cnt_reg   <= len;
            chk_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= S_LEN_H;
          end
        end
        S_LEN_H: begin
          if (!tx_busy) begin
            tx_data   <= len_reg[LEN_W-1 -: 8];
            chk_reg   <= chk_reg ^ len_reg[LEN_W-1 -: 8];
            tx_en     <= 1'b1;
            guard_reg <= 1'b1;
            ret_reg   <= S_LEN_L;
            state_reg <= S_WAIT;
          end
        end
        S_LEN_L: begin
          if (!tx_busy) begin
            tx_data   <= len_reg[7:0];
            chk_reg   <= chk_reg ^ len_reg[7:0];
            tx_en     <= 1'b1;
            guard_reg <= 1'b1;
            ret_reg   <= S_CMD;
            state_reg <= S_WAIT;
          end
        end
        S_CMD: begin
          if (!tx_busy) begin
            tx_data   <= cmd_reg;
            chk_reg   <= chk_reg ^ cmd_reg;
            tx_en     <= 1'b1;
            guard_reg <= 1'b1;
            ret_reg   <= S_RD;
            state_reg <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (guard_reg) begin
            guard_reg <= 1'b0;
          end else if (!tx_busy) begin
            if (ret_reg == S_RD) begin
              if (cnt_reg != '0)
                state_reg <= S_RD;
              else
                state_reg <= CHK_EN ? S_CHK : S_FIN;
            end else begin
              state_reg <= ret_reg;
            end
          end
        end
        S_RD: begin
          if (!fifo_empty) begin
            fifo_rd   <= 1'b1;
            state_reg <= S_RDW;
          end
        end
        // fifo_rd is visible this cycle; read data arrives on the next one
        S_RDW: state_reg <= S_LAT;
        S_LAT: begin
          tx_data   <= fifo_dout;
          chk_reg   <= chk_reg ^ fifo_dout;
          tx_en     <= 1'b1;
          guard_reg <= 1'b1;
          cnt_reg   <= cnt_reg - LEN_W'(1);
          ret_reg   <= S_RD;
          state_reg <= S_WAIT;
        end
        S_CHK: begin
          if (!tx_busy) begin
            tx_data   <= chk_reg;
            tx_en     <= 1'b1;
            guard_reg <= 1'b1;
            ret_reg   <= S_FIN;
            state_reg <= S_WAIT;
          end
        end
        S_FIN: begin
          tx_done   <= 1'b1;
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fe_tx_framer.sv
// Scoreboard bench for fe_tx_framer with FIFO and UART busy models.
module tb_fe_tx_framer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  cmd = '0;
  logic [15:0] len = '0;
  logic        fifo_empty;
  logic [7:0]  fifo_dout = '0;
  logic        fifo_rd;
  logic        tx_busy;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        busy;
  logic        tx_done;

  fe_tx_framer #(.LEN_W(16), .CHK_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .len(len),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd(fifo_rd),
    .tx_busy(tx_busy), .tx_en(tx_en), .tx_data(tx_data), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  // payload FIFO model: registered read data
  logic [7:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic fifo_flush = 1'b0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_flush) rd_ptr <= wr_ptr;
    else if (fifo_rd) begin
      fifo_dout <= mem[rd_ptr[9:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // UART model: busy for busy_len cycles starting the cycle after tx_en
  int busy_len = 10;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (!rst_n) busy_cnt <= 0;
    else if (tx_en) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // monitor
  int n_tx = 0, n_rd = 0, n_done = 0;
  logic prev_en = 1'b0;
  logic [7:0] e;
  always @(negedge clk) begin
    if (tx_en) begin
      n_tx++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL byte_extra: got %02h, expected no byte", tx_data);
      end else begin
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          errors++;
          $display("FAIL byte: got %02h, expected %02h", tx_data, e);
        end else
          $display("byte %02h ok", tx_data);
      end
      checks++;
      if (tx_busy || prev_en) begin
        errors++;
        $display("FAIL handshake: tx_busy=%0b prev_tx_en=%0b, expected 0/0", tx_busy, prev_en);
      end
    end
    if (fifo_rd) begin
      n_rd++;
      checks++;
      if (fifo_empty) begin
        errors++;
        $display("FAIL rd_empty: fifo_rd=1 while fifo_empty=1, expected no read");
      end
    end
    if (tx_done) n_done++;
    prev_en = tx_en;
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end else
      $display("check %s = %0h ok", name, got);
  endtask

  task automatic push_fifo(input logic [7:0] b);
    mem[wr_ptr[9:0]] = b;
    wr_ptr++;
  endtask

  task automatic exp_hdr(input logic [7:0] c, input logic [15:0] l);
    exp_q.push_back(l[15:8]);
    exp_q.push_back(l[7:0]);
    exp_q.push_back(c);
  endtask

  task automatic pulse_start(input logic [7:0] c, input logic [15:0] l);
    @(negedge clk);
    cmd = c; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_frame(input string name, input int want_rd, input int rd0, input int done0);
    int t = 0;
    while (n_done == done0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (n_done == done0) begin
      errors++;
      $display("FAIL %s_timeout: got no tx_done, expected one", name);
    end
    repeat (3) @(negedge clk);
    check({name, "_reads"}, n_rd - rd0, want_rd);
    check({name, "_done"}, n_done - done0, 1);
    check({name, "_left"}, exp_q.size(), 0);
    check({name, "_busy"}, int'(busy), 0);
  endtask

  task automatic wait_tx(input int target);
    int t = 0;
    while (n_tx < target && t < 20000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (n_tx < target) begin
      errors++;
      $display("FAIL wait_tx: got %0d bytes, expected %0d", n_tx, target);
    end
  endtask

  initial begin
    int rd0, done0, tx0;
    logic [7:0] c;

    repeat (3) @(negedge clk);
    check("rst_tx_en", int'(tx_en), 0);
    check("rst_fifo_rd", int'(fifo_rd), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_tx_done", int'(tx_done), 0);
    rst_n = 1'b1;

    // basic frame
    push_fifo(8'h11); push_fifo(8'h23);
    exp_hdr(8'h31, 16'd2);
    exp_q.push_back(8'h11); exp_q.push_back(8'h23); exp_q.push_back(8'h01);
    rd0 = n_rd; done0 = n_done;
    pulse_start(8'h31, 16'd2);
    check("basic_busy_hi", int'(busy), 1);
    finish_frame("basic", 2, rd0, done0);

    // zero length
    exp_hdr(8'h55, 16'd0);
    exp_q.push_back(8'h55);
    rd0 = n_rd; done0 = n_done;
    pulse_start(8'h55, 16'd0);
    finish_frame("zero", 0, rd0, done0);

    // FIFO underrun: one byte available, then empty for 50 cycles
    push_fifo(8'hAA);
    exp_hdr(8'h40, 16'd3);
    exp_q.push_back(8'hAA); exp_q.push_back(8'hBB);
    exp_q.push_back(8'hCC); exp_q.push_back(8'h9E);
    rd0 = n_rd; done0 = n_done; tx0 = n_tx;
    pulse_start(8'h40, 16'd3);
    wait_tx(tx0 + 4);
    repeat (50) @(negedge clk);
    check("underrun_tx", n_tx - tx0, 4);
    check("underrun_rd", n_rd - rd0, 1);
    push_fifo(8'hBB); push_fifo(8'hCC);
    finish_frame("underrun", 3, rd0, done0);

    // fast UART, start pulsed mid-frame
    busy_len = 1;
    push_fifo(8'h01); push_fifo(8'h80);
    exp_hdr(8'h7E, 16'd2);
    exp_q.push_back(8'h01); exp_q.push_back(8'h80); exp_q.push_back(8'hFD);
    rd0 = n_rd; done0 = n_done;
    pulse_start(8'h7E, 16'd2);
    repeat (4) @(negedge clk);
    pulse_start(8'hFF, 16'd5);
    finish_frame("fast", 2, rd0, done0);

    // slow UART, start pulsed mid-frame
    busy_len = 200;
    push_fifo(8'h34);
    exp_hdr(8'h12, 16'd1);
    exp_q.push_back(8'h34); exp_q.push_back(8'h27);
    rd0 = n_rd; done0 = n_done;
    pulse_start(8'h12, 16'd1);
    repeat (30) @(negedge clk);
    pulse_start(8'hFF, 16'd5);
    finish_frame("slow", 1, rd0, done0);

    // reset during payload
    busy_len = 10;
    for (int i = 0; i < 4; i++) push_fifo(8'hC0 + 8'(i));
    exp_hdr(8'h22, 16'd4);
    exp_q.push_back(8'hC0);
    tx0 = n_tx;
    pulse_start(8'h22, 16'd4);
    wait_tx(tx0 + 4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_en", int'(tx_en), 0);
    check("mid_rst_fifo_rd", int'(fifo_rd), 0);
    check("mid_rst_tx_data", int'(tx_data), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_tx_done", int'(tx_done), 0);
    exp_q.delete();
    fifo_flush = 1'b1;
    @(negedge clk);
    fifo_flush = 1'b0;
    rst_n = 1'b1;
    push_fifo(8'h0F);
    exp_hdr(8'hA0, 16'd1);
    exp_q.push_back(8'h0F); exp_q.push_back(8'hAE);
    rd0 = n_rd; done0 = n_done;
    pulse_start(8'hA0, 16'd1);
    finish_frame("after_rst", 1, rd0, done0);

    // 256-byte payload with incrementing pattern
    busy_len = 2;
    exp_hdr(8'h5A, 16'h0100);
    c = 8'h01 ^ 8'h00 ^ 8'h5A;
    for (int i = 0; i < 256; i++) begin
      push_fifo(8'(i));
      exp_q.push_back(8'(i));
      c = c ^ 8'(i);
    end
    exp_q.push_back(c);
    rd0 = n_rd; done0 = n_done;
    pulse_start(8'h5A, 16'h0100);
    finish_frame("large", 256, rd0, done0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fe_tx_framer.md
Name: fe_tx_framer

Overview:
- Transmit-side framer: builds the response frame returned over the UART.
- Frame layout: length high byte, length low byte, command byte. This is the same header order the receive front end parses.
- Header is followed by LEN payload bytes pulled from the data FIFO, then an optional XOR checksum byte.
- Sits between the command/FIFO logic and the UART byte transmitter; drives one byte at a time through a start/busy handshake.

Parameters:
- LEN_W, 16, width of the payload length field (fixed at 16; header always carries 2 length bytes).
- CHK_EN, 1, 1 = append XOR checksum byte after payload; 0 = omit.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to send a frame; sampled only in IDLE.
- cmd  input  8  command byte, captured on accepted start.
- len  input  16  payload byte count, captured on accepted start.
- fifo_empty  input  1  payload FIFO empty flag.
- fifo_dout  input  8  FIFO read data, valid the cycle after fifo_rd.
- fifo_rd  output  1  one-cycle FIFO read strobe.
- tx_busy  input  1  UART transmitter busy; rises the cycle after tx_en, falls when the byte is fully shifted out.
- tx_en  output  1  one-cycle strobe: tx_data is valid, start transmission.
- tx_data  output  8  byte to transmit, held stable from tx_en until the next tx_en.
- busy  output  1  frame in progress.
- tx_done  output  1  one-cycle pulse when the last byte has completed.

Behaviour:
- Reset values: fifo_rd=0, tx_en=0, tx_data=0, busy=0, tx_done=0. State=IDLE; internal cmd/len/count/checksum registers = 0.
- Reset mid-frame aborts immediately. No partial-frame recovery; the FIFO is not flushed by this block.
- States:
  - IDLE: on start=1, register cmd and len, clear checksum, go to LEN_H. busy=1 from the next cycle. start in any other state is ignored.
  - LEN_H / LEN_L / CMD: each loads its byte into tx_data and issues tx_en, then moves to WAIT.
  - WAIT: wait for tx_busy==0. tx_busy is not examined in the cycle immediately after tx_en (guard cycle). Next state after the byte completes:
    - after CMD: RD if remaining count != 0; otherwise CHK (CHK_EN=1) or FIN (CHK_EN=0).
    - after a payload byte: same rule on the decremented count.
    - after CHK: FIN.
  - RD: if fifo_empty=1, stall in RD with no strobe. Otherwise assert fifo_rd for one cycle and go to LAT.
  - LAT: capture fifo_dout into tx_data, issue tx_en, decrement remaining count, go to WAIT.
  - CHK: tx_data = running XOR, issue tx_en, go to WAIT.
  - FIN: tx_done=1 for one cycle, busy=0 from the next cycle, return to IDLE.
- tx_en is never asserted while tx_busy=1, and never on two consecutive cycles.
- Exactly one tx_en per transmitted byte; exactly len fifo_rd pulses per frame.
- Checksum = XOR of every byte sent before it: LEN_H, LEN_L, CMD and all payload bytes. It updates in the same cycle as each tx_en.
- len=0: header, then checksum (or FIN); no fifo_rd.
- len=16'hFFFF: 65535 payload bytes; the count must not wrap.
- A new start is accepted at the earliest on the cycle after tx_done.

Test Plan:
- Basic frame: start with cmd=0x31, len=2; FIFO holds 0x11, 0x23; UART model holds tx_busy 10 cycles per byte. Required: tx_data sequence 0x00, 0x02, 0x31, 0x11, 0x23, 0x01; exactly 2 fifo_rd pulses; one tx_done; busy low afterwards.
- Zero length: start with cmd=0x55, len=0. Required: bytes 0x00, 0x00, 0x55, 0x55; no fifo_rd. With CHK_EN=0: bytes 0x00, 0x00, 0x55 only.
- FIFO underrun: len=3, FIFO empty after the first byte for 50 cycles. Required: no fifo_rd and no tx_en while empty; frame resumes on refill; payload order preserved.
- Handshake stress: tx_busy held 1 cycle vs 200 cycles per byte, and start pulsed while busy. Required: no tx_en during tx_busy=1; no back-to-back tx_en; mid-frame start ignored and output bytes unchanged.
- Reset mid-frame: assert rst_n=0 during the payload. Required: all outputs 0 immediately. A new frame with cmd=0xA0, len=1, data 0x0F after reset yields 0x00, 0x01, 0xA0, 0x0F, 0xAE.
- Large length: len=0x0100 with an incrementing FIFO pattern. Required: bytes 0x01, 0x00, cmd header; 256 reads; checksum equal to the reference XOR.
